// File: rtl/score_tracker.sv
// N-digit saturating BCD score with PLAY/OVER game state, blinking seven-segment output.
// Optional high-score tracking is compiled in when HISCORE_EN is defined.
module score_tracker #(
  parameter int DIGITS     = 2,
  parameter int BLINK_BITS = 23
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    goodCollButton,
  input  logic                    badCollButton,
  input  logic                    restartButton,
  output logic [4*DIGITS-1:0]     score_bcd,
  output logic [7*DIGITS-1:0]     ss,
  output logic [7*DIGITS-1:0]     dispScore,
  output logic                    gameOver,
  output logic                    blinkToggle,
  output logic [BLINK_BITS-1:0]   blinkCounter,
  output logic [4*DIGITS-1:0]     hiscore_bcd,
  output logic                    newHigh
);

  localparam int SW = 4*DIGITS;

  typedef enum logic {S_PLAY = 1'b0, S_OVER = 1'b1} state_t;

  function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
    logic [SW-1:0] r;
    logic          carry;
    logic          sat;
    r     = v;
    carry = 1'b1;
    sat   = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] != 4'd9) sat = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return sat ? v : r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  logic                  r_good_prev, r_bad_prev, r_restart_prev;
  state_t                r_state;
  logic [SW-1:0]         r_score;
  logic [BLINK_BITS-1:0] r_blink;

  logic                  w_good_edge, w_bad_edge, w_restart_edge;
  state_t                w_next_state;
  logic [SW-1:0]         w_next_score;
  logic                  w_enter_over;

  assign w_good_edge    = goodCollButton & ~r_good_prev;
  assign w_bad_edge     = badCollButton  & ~r_bad_prev;
  assign w_restart_edge = restartButton  & ~r_restart_prev;

  // Event priority: restart over bad over good.
  always_comb begin
    w_next_state = r_state;
    w_next_score = r_score;
    w_enter_over = 1'b0;
    case (r_state)
      S_PLAY: begin
        if (w_restart_edge) begin
          w_next_score = '0;
        end else if (w_bad_edge) begin
          w_next_state = S_OVER;
          w_enter_over = 1'b1;
        end else if (w_good_edge) begin
          w_next_score = bcd_inc(r_score);
        end
      end
      S_OVER: begin
        if (w_restart_edge) begin
          w_next_score = '0;
          w_next_state = S_PLAY;
        end
      end
      default: w_next_state = S_PLAY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_good_prev    <= 1'b0;
      r_bad_prev     <= 1'b0;
      r_restart_prev <= 1'b0;
      r_state        <= S_PLAY;
      r_score        <= '0;
    end else begin
      r_good_prev    <= goodCollButton;
      r_bad_prev     <= badCollButton;
      r_restart_prev <= restartButton;
      r_state        <= w_next_state;
      r_score        <= w_next_score;
    end
  end

  // Counter stays 0 on the entry cycle, so it reads 1 after the first OVER posedge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_blink <= '0;
    else if (r_state == S_OVER && !w_restart_edge)
      r_blink <= r_blink + BLINK_BITS'(1);
    else
      r_blink <= '0;
  end

`ifdef HISCORE_EN
  logic [SW-1:0] r_hiscore;
  logic          r_new_high;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hiscore  <= '0;
      r_new_high <= 1'b0;
    end else if (w_restart_edge) begin
      r_new_high <= 1'b0;
    end else if (w_enter_over) begin
      if (r_score > r_hiscore) begin
        r_hiscore  <= r_score;
        r_new_high <= 1'b1;
      end else begin
        r_new_high <= 1'b0;
      end
    end
  end

  assign hiscore_bcd = r_hiscore;
  assign newHigh     = r_new_high;
`else
  assign hiscore_bcd = '0;
  assign newHigh     = 1'b0;
`endif

  always_comb begin
    ss = '0;
    for (int i = 0; i < DIGITS; i++)
      ss[7*i +: 7] = seg7(r_score[4*i +: 4]);
  end

  assign score_bcd    = r_score;
  assign gameOver     = (r_state == S_OVER);
  assign blinkCounter = r_blink;
  assign blinkToggle  = r_blink[BLINK_BITS-1];
  assign dispScore    = blinkToggle ? '0 : ss;

endmodule

// File: tb/tb_score_tracker.sv
// Self-checking bench for score_tracker: directed scenarios plus randomized traffic
// against a decimal-arithmetic reference model.
module tb_score_tracker;
  localparam int DIGITS = 2;
  localparam int BB     = 4;
  localparam int MAXS   = 99;
  localparam int PERIOD = 16;
  localparam int HALF   = 8;
`ifdef HISCORE_EN
  localparam bit HI = 1'b1;
`else
  localparam bit HI = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic g = 1'b0, b = 1'b0, r = 1'b0;
  logic [4*DIGITS-1:0] score_bcd, hiscore_bcd;
  logic [7*DIGITS-1:0] ss, dispScore;
  logic                gameOver, blinkToggle, newHigh;
  logic [BB-1:0]       blinkCounter;

  score_tracker #(.DIGITS(DIGITS), .BLINK_BITS(BB)) dut (
    .clk(clk), .rst(rst),
    .goodCollButton(g), .badCollButton(b), .restartButton(r),
    .score_bcd(score_bcd), .ss(ss), .dispScore(dispScore),
    .gameOver(gameOver), .blinkToggle(blinkToggle), .blinkCounter(blinkCounter),
    .hiscore_bcd(hiscore_bcd), .newHigh(newHigh)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  int m_score, m_blink, m_hi;
  bit m_over, m_nh, pg, pb, pr;

  logic [6:0] SEG [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] res;
    int t;
    t = v;
    res = '0;
    for (int i = 0; i < DIGITS; i++) begin
      res[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return res;
  endfunction

  function automatic logic [7*DIGITS-1:0] exp_ss(input int v);
    logic [7*DIGITS-1:0] res;
    int t;
    t = v;
    res = '0;
    for (int i = 0; i < DIGITS; i++) begin
      res[7*i +: 7] = SEG[t % 10];
      t = t / 10;
    end
    return res;
  endfunction

  task automatic model_reset();
    m_score = 0; m_blink = 0; m_hi = 0;
    m_over = 0; m_nh = 0; pg = 0; pb = 0; pr = 0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    g = 0; b = 0; r = 0; rst = 0;
    @(negedge clk);
    rst = 1;
    model_reset();
  endtask

  // One clock cycle: drive at negedge, update the model at posedge, settle 1 time unit.
  task automatic cyc(input bit gi, input bit bi, input bit ri);
    bit ge, be, re;
    @(negedge clk);
    g = gi; b = bi; r = ri;
    @(posedge clk);
    ge = gi && !pg; be = bi && !pb; re = ri && !pr;
    pg = gi; pb = bi; pr = ri;
    if (!m_over) begin
      m_blink = 0;
      if (re) begin
        m_score = 0; m_nh = 0;
      end else if (be) begin
        m_over = 1;
        if (HI) begin
          if (m_score > m_hi) begin m_hi = m_score; m_nh = 1; end
          else m_nh = 0;
        end
      end else if (ge) begin
        m_score = (m_score < MAXS) ? m_score + 1 : MAXS;
      end
    end else begin
      if (re) begin
        m_over = 0; m_score = 0; m_blink = 0; m_nh = 0;
      end else begin
        m_blink = (m_blink + 1) % PERIOD;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    g = 0; b = 0; r = 0; rst = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1;
    model_reset();
    #1;
    compared++; if (score_bcd !== 8'h00) begin mismatched++; $display("FAIL reset_score got %h want 00", score_bcd); end
    compared++; if (ss !== {7'h3F, 7'h3F}) begin mismatched++; $display("FAIL reset_ss got %h want %h", ss, {7'h3F, 7'h3F}); end
    compared++; if (dispScore !== {7'h3F, 7'h3F}) begin mismatched++; $display("FAIL reset_disp got %h want %h", dispScore, {7'h3F, 7'h3F}); end
    compared++; if (gameOver !== 1'b0) begin mismatched++; $display("FAIL reset_gameover got %b want 0", gameOver); end
    compared++; if (blinkCounter !== 4'd0) begin mismatched++; $display("FAIL reset_blink got %0d want 0", blinkCounter); end
    compared++; if (blinkToggle !== 1'b0) begin mismatched++; $display("FAIL reset_toggle got %b want 0", blinkToggle); end
    compared++; if (hiscore_bcd !== 8'h00) begin mismatched++; $display("FAIL reset_hiscore got %h want 00", hiscore_bcd); end
    compared++; if (newHigh !== 1'b0) begin mismatched++; $display("FAIL reset_newhigh got %b want 0", newHigh); end
  endtask

  task automatic test_counting();
    reset_dut();
    repeat (12) begin
      cyc(1, 0, 0);
      repeat (50) cyc(0, 0, 0);
    end
    compared++; if (score_bcd !== 8'h12) begin mismatched++; $display("FAIL count12_score got %h want 12", score_bcd); end
    compared++; if (ss[13:7] !== 7'h06) begin mismatched++; $display("FAIL count12_ss1 got %h want 06", ss[13:7]); end
    compared++; if (ss[6:0] !== 7'h5B) begin mismatched++; $display("FAIL count12_ss0 got %h want 5b", ss[6:0]); end
    repeat (20) cyc(1, 0, 0);
    cyc(0, 0, 0);
    compared++; if (score_bcd !== 8'h13) begin mismatched++; $display("FAIL hold_score got %h want 13", score_bcd); end
  endtask

  task automatic test_saturation();
    reset_dut();
    repeat (105) begin cyc(1, 0, 0); cyc(0, 0, 0); end
    compared++; if (score_bcd !== 8'h99) begin mismatched++; $display("FAIL sat_score got %h want 99", score_bcd); end
    compared++; if (ss !== {7'h6F, 7'h6F}) begin mismatched++; $display("FAIL sat_ss got %h want %h", ss, {7'h6F, 7'h6F}); end
    cyc(1, 0, 0);
    compared++; if (score_bcd !== 8'h99) begin mismatched++; $display("FAIL sat_extra got %h want 99", score_bcd); end
  endtask

  task automatic test_gameover_blink();
    logic [7*DIGITS-1:0] ed;
    reset_dut();
    repeat (4) begin cyc(1, 0, 0); cyc(0, 0, 0); end
    cyc(0, 1, 0);
    compared++; if (gameOver !== 1'b1) begin mismatched++; $display("FAIL over_entry got %b want 1", gameOver); end
    compared++; if (score_bcd !== 8'h04) begin mismatched++; $display("FAIL over_score got %h want 04", score_bcd); end
    for (int i = 0; i < 2*PERIOD; i++) begin
      ed = ((i % PERIOD) < HALF) ? exp_ss(4) : '0;
      compared++; if (dispScore !== ed) begin mismatched++; $display("FAIL blink_disp cyc %0d got %h want %h", i, dispScore, ed); end
      compared++; if (blinkCounter !== BB'(i % PERIOD)) begin mismatched++; $display("FAIL blink_cnt cyc %0d got %0d want %0d", i, blinkCounter, i % PERIOD); end
      cyc(0, 0, 0);
    end
    repeat (3) begin cyc(1, 0, 0); cyc(0, 0, 0); end
    compared++; if (score_bcd !== 8'h04) begin mismatched++; $display("FAIL over_good_ignored got %h want 04", score_bcd); end
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    cyc(1, 1, 0);
    compared++; if (gameOver !== 1'b1) begin mismatched++; $display("FAIL goodbad_over got %b want 1", gameOver); end
    compared++; if (score_bcd !== 8'h00) begin mismatched++; $display("FAIL goodbad_score got %h want 00", score_bcd); end
    cyc(0, 0, 0);
  endtask

  task automatic test_restart();
    // Entered with the DUT in OVER from the previous scenario.
    repeat (5) cyc(0, 0, 0);
    cyc(0, 0, 1);
    compared++; if (gameOver !== 1'b0) begin mismatched++; $display("FAIL restart_state got %b want 0", gameOver); end
    compared++; if (score_bcd !== 8'h00) begin mismatched++; $display("FAIL restart_score got %h want 00", score_bcd); end
    compared++; if (blinkCounter !== 4'd0) begin mismatched++; $display("FAIL restart_blink got %0d want 0", blinkCounter); end
    cyc(0, 0, 0);
    repeat (2) begin cyc(1, 0, 0); cyc(0, 0, 0); end
    cyc(0, 1, 1);
    compared++; if (gameOver !== 1'b0) begin mismatched++; $display("FAIL rstbad_state got %b want 0", gameOver); end
    compared++; if (score_bcd !== 8'h00) begin mismatched++; $display("FAIL rstbad_score got %h want 00", score_bcd); end
    cyc(0, 0, 0);
  endtask

  task automatic test_hiscore();
    reset_dut();
    repeat (4) begin cyc(1, 0, 0); cyc(0, 0, 0); end
    cyc(0, 1, 0);
    compared++; if (hiscore_bcd !== (HI ? 8'h04 : 8'h00)) begin mismatched++; $display("FAIL hi_first got %h want %h", hiscore_bcd, HI ? 8'h04 : 8'h00); end
    compared++; if (newHigh !== HI) begin mismatched++; $display("FAIL newhigh_first got %b want %b", newHigh, HI); end
    cyc(0, 0, 1);
    compared++; if (newHigh !== 1'b0) begin mismatched++; $display("FAIL newhigh_restart got %b want 0", newHigh); end
    cyc(0, 0, 0);
    repeat (3) begin cyc(1, 0, 0); cyc(0, 0, 0); end
    cyc(0, 1, 0);
    compared++; if (hiscore_bcd !== (HI ? 8'h04 : 8'h00)) begin mismatched++; $display("FAIL hi_kept got %h want %h", hiscore_bcd, HI ? 8'h04 : 8'h00); end
    compared++; if (newHigh !== 1'b0) begin mismatched++; $display("FAIL newhigh_lower got %b want 0", newHigh); end
    cyc(0, 0, 0);
  endtask

  task automatic test_async_reset();
    reset_dut();
    repeat (5) begin cyc(1, 0, 0); cyc(0, 0, 0); end
    cyc(0, 1, 0);
    repeat (10) cyc(0, 0, 0);
    @(negedge clk);
    #2 rst = 0;
    #1;
    compared++; if (score_bcd !== 8'h00) begin mismatched++; $display("FAIL arst_score got %h want 00", score_bcd); end
    compared++; if (gameOver !== 1'b0) begin mismatched++; $display("FAIL arst_over got %b want 0", gameOver); end
    compared++; if (blinkCounter !== 4'd0) begin mismatched++; $display("FAIL arst_blink got %0d want 0", blinkCounter); end
    compared++; if (dispScore !== {7'h3F, 7'h3F}) begin mismatched++; $display("FAIL arst_disp got %h want %h", dispScore, {7'h3F, 7'h3F}); end
    compared++; if (hiscore_bcd !== 8'h00) begin mismatched++; $display("FAIL arst_hiscore got %h want 00", hiscore_bcd); end
    @(negedge clk);
    rst = 1;
    model_reset();
  endtask

  task automatic test_random();
    logic [7*DIGITS-1:0] es, ed;
    reset_dut();
    for (int i = 0; i < 800; i++) begin
      cyc($urandom_range(0, 1) == 0, $urandom_range(0, 24) == 0, $urandom_range(0, 39) == 0);
      es = exp_ss(m_score);
      ed = (m_blink >= HALF) ? '0 : es;
      compared++; if (score_bcd !== to_bcd(m_score)) begin mismatched++; $display("FAIL rnd_score cyc %0d got %h want %h", i, score_bcd, to_bcd(m_score)); end
      compared++; if (ss !== es) begin mismatched++; $display("FAIL rnd_ss cyc %0d got %h want %h", i, ss, es); end
      compared++; if (dispScore !== ed) begin mismatched++; $display("FAIL rnd_disp cyc %0d got %h want %h", i, dispScore, ed); end
      compared++; if (gameOver !== m_over) begin mismatched++; $display("FAIL rnd_over cyc %0d got %b want %b", i, gameOver, m_over); end
      compared++; if (blinkCounter !== BB'(m_blink)) begin mismatched++; $display("FAIL rnd_blink cyc %0d got %0d want %0d", i, blinkCounter, m_blink); end
      compared++; if (blinkToggle !== (m_blink >= HALF)) begin mismatched++; $display("FAIL rnd_toggle cyc %0d got %b", i, blinkToggle); end
      compared++; if (hiscore_bcd !== to_bcd(m_hi)) begin mismatched++; $display("FAIL rnd_hiscore cyc %0d got %h want %h", i, hiscore_bcd, to_bcd(m_hi)); end
      compared++; if (newHigh !== m_nh) begin mismatched++; $display("FAIL rnd_newhigh cyc %0d got %b want %b", i, newHigh, m_nh); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    test_reset();
    test_counting();
    test_saturation();
    test_gameover_blink();
    test_restart();
    test_hiscore();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
